alu_responder: RTL and testbench
================================

ALU_RESPONDER -- requirements
Module: alu_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the operand and result width.
REQ-002 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port req_valid, input, 1, the request is present.
REQ-005 SHALL have port req_ready, output, 1, the block accepts a request this cycle.
REQ-006 SHALL have port ALU_Control, input, 6, the operation code.
REQ-007 SHALL have ports operand_A and operand_B, input, DATA_WIDTH, the request operands.
REQ-008 SHALL have port resp_valid, output, 1, the response is present.
REQ-009 SHALL have port resp_ready, input, 1, the consumer takes the response.
REQ-010 SHALL have port ALU_result, output, DATA_WIDTH, the registered result.
REQ-011 SHALL have ports zero and branch, output, 1 each, the registered result flags.
REQ-012 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-013 SHALL accept a request when req_valid and req_ready are both high in the same cycle, capturing ALU_Control, operand_A and operand_B.
REQ-014 SHALL decode ALU_Control as follows: 000000 ADD; 001000 SUB; 000001 SLL; 000101 SRL; 001101 SRA; 000010 SLT; 000011 SLTU; 000100 XOR; 000110 OR; 000111 AND; 010000 BEQ; 010001 BNE; 010100 BLT; 010101 BGE; 010110 BLTU; 010111 BGEU; 011111 pass operand_A.
REQ-015 SHALL wrap add and subtract modulo 2^DATA_WIDTH and compare signed for SLT/BLT/BGE and unsigned for SLTU/BLTU/BGEU.
REQ-016 SHALL take the shift amount from operand_B[4:0], with SRA replicating operand_A's MSB.
REQ-017 SHALL, for SLT and SLTU, set ALU_result to the comparison bit zero-extended, and set branch to 0.
REQ-018 SHALL, for branch ops, set branch to the condition and set ALU_result to the condition zero-extended.
REQ-019 SHALL, for every non-branch op, set branch to 0.
REQ-020 SHALL drive zero high exactly when ALU_result equals 0.
REQ-021 SHALL, for any undefined code, produce ALU_result 0, zero 1 and branch 0.
REQ-022 SHALL implement an FSM with states IDLE, SHIFT and RESP.
REQ-023 SHALL, in IDLE on accept, go to SHIFT for an iterative shift with nonzero amount, and otherwise to RESP with the result registered.
REQ-024 SHALL, in SHIFT, shift the working register by one bit per cycle and decrement the count, going to RESP when the count reaches 0.
REQ-025 SHALL drive resp_valid high only in RESP.
REQ-026 SHALL hold ALU_result, zero and branch stable while resp_valid is high and resp_ready is low.
REQ-027 SHALL drive req_ready as (state==IDLE) OR (state==RESP AND resp_ready).
REQ-028 SHALL, on a simultaneous response handoff and new accept in RESP, process the new request exactly as from IDLE, sustaining one non-shift result per cycle.
REQ-029 SHALL, in RESP with resp_ready high and no accept, return to IDLE.
REQ-030 SHALL keep req_ready low and ignore req_valid while in SHIFT.

Reset
REQ-031 SHALL, on reset high at a clock edge, enter IDLE and clear resp_valid, ALU_result, branch, busy and the shift count to 0, and set zero to 1.
REQ-032 SHALL discard any in-flight shift or unconsumed response on reset mid-operation, with no response emitted for it.
REQ-033 SHALL drive req_ready low during the reset cycle and high from the first cycle after reset deasserts.

Configuration
REQ-034 SHALL, with macro ALU_RESPONDER_ITER_SHIFT_EN defined, perform SLL/SRL/SRA iteratively per REQ-024, giving accept-to-resp_valid latency of 1+shamt cycles.
REQ-035 SHALL, without ALU_RESPONDER_ITER_SHIFT_EN, omit the SHIFT state and perform all shifts in a single-cycle barrel shifter, giving latency 1 for every op.

Verification
REQ-036 SHALL cover: ADD with A=2, B=4 -> resp_valid 1 cycle after accept, ALU_result=6, zero=0, branch=0.
REQ-037 SHALL cover: SUB with A=2, B=4 -> ALU_result=0xFFFFFFFE; SLT with A=2, B=4 -> ALU_result=1.
REQ-038 SHALL cover: SRA with A=0x80000000, B=4 -> ALU_result=0xF8000000, resp_valid 5 cycles after accept with macro and 1 cycle without; SRA with A=0xA, B=4 -> ALU_result=0, zero=1.
REQ-039 SHALL cover: BGEU with A=2, B=4 -> branch=0, ALU_result=0, zero=1; BLTU with the same operands -> branch=1.
REQ-040 SHALL cover: resp_ready held low for 3 cycles -> outputs stable, req_ready low; then resp_ready high together with a new ADD -> back-to-back responses with no gap.
REQ-041 SHALL cover: reset asserted in the second SHIFT cycle -> next cycle state IDLE, resp_valid=0, zero=1, and no stale response follows.

Source files
------------

// File: rtl/alu_responder.sv
// alu_responder: request/response wrapper around a small RV-style ALU.
// One request is accepted at a time. Its result and flags are registered and then
// presented on the response channel until the consumer takes them.
// Optional feature macro ALU_RESPONDER_ITER_SHIFT_EN: when it is defined, SLL/SRL/SRA
// with a nonzero shift amount run one bit per cycle in a SHIFT state. When it is not
// defined, every operation (shifts included) completes in one cycle through a barrel
// shifter, and the SHIFT state does not exist.
module alu_responder #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [5:0]            ALU_Control,
    input  logic [DATA_WIDTH-1:0] operand_A,
    input  logic [DATA_WIDTH-1:0] operand_B,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] ALU_result,
    output logic                  zero,
    output logic                  branch,
    output logic                  busy
);

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b001000;
    localparam logic [5:0] OP_SLL  = 6'b000001;
    localparam logic [5:0] OP_SRL  = 6'b000101;
    localparam logic [5:0] OP_SRA  = 6'b001101;
    localparam logic [5:0] OP_SLT  = 6'b000010;
    localparam logic [5:0] OP_SLTU = 6'b000011;
    localparam logic [5:0] OP_XOR  = 6'b000100;
    localparam logic [5:0] OP_OR   = 6'b000110;
    localparam logic [5:0] OP_AND  = 6'b000111;
    localparam logic [5:0] OP_BEQ  = 6'b010000;
    localparam logic [5:0] OP_BNE  = 6'b010001;
    localparam logic [5:0] OP_BLT  = 6'b010100;
    localparam logic [5:0] OP_BGE  = 6'b010101;
    localparam logic [5:0] OP_BLTU = 6'b010110;
    localparam logic [5:0] OP_BGEU = 6'b010111;
    localparam logic [5:0] OP_PASS = 6'b011111;

`ifdef ALU_RESPONDER_ITER_SHIFT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, RESP = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, RESP = 2'd2} state_t;
`endif

    state_t state_q;
    state_t state_d;

    logic [DATA_WIDTH-1:0] result_q;
    logic                  zero_q;
    logic                  branch_q;

    logic [DATA_WIDTH-1:0] calcResult;
    logic                  calcBranch;
    logic                  signedLess;
    logic                  unsignedLess;
    logic                  accept;
    logic [4:0]            shamt;

    assign shamt        = operand_B[4:0];
    assign signedLess   = $signed(operand_A) < $signed(operand_B);
    assign unsignedLess = operand_A < operand_B;
    assign accept       = req_valid && req_ready;

`ifdef ALU_RESPONDER_ITER_SHIFT_EN
    logic [4:0] count_q;
    logic [5:0] ctrl_q;
    logic       iterStart;

    assign iterStart = ((ALU_Control == OP_SLL) || (ALU_Control == OP_SRL) ||
                        (ALU_Control == OP_SRA)) && (shamt != 5'd0);
`endif

    // Single-cycle ALU on the live request inputs; undefined codes give result 0, branch 0.
    always_comb begin
        calcResult = '0;
        calcBranch = 1'b0;
        case (ALU_Control)
            OP_ADD:  calcResult = operand_A + operand_B;
            OP_SUB:  calcResult = operand_A - operand_B;
            OP_SLL:  calcResult = operand_A << shamt;
            OP_SRL:  calcResult = operand_A >> shamt;
            OP_SRA:  calcResult = $signed(operand_A) >>> shamt;
            OP_SLT:  calcResult = {{(DATA_WIDTH-1){1'b0}}, signedLess};
            OP_SLTU: calcResult = {{(DATA_WIDTH-1){1'b0}}, unsignedLess};
            OP_XOR:  calcResult = operand_A ^ operand_B;
            OP_OR:   calcResult = operand_A | operand_B;
            OP_AND:  calcResult = operand_A & operand_B;
            OP_BEQ:  calcBranch = (operand_A == operand_B);
            OP_BNE:  calcBranch = (operand_A != operand_B);
            OP_BLT:  calcBranch = signedLess;
            OP_BGE:  calcBranch = !signedLess;
            OP_BLTU: calcBranch = unsignedLess;
            OP_BGEU: calcBranch = !unsignedLess;
            OP_PASS: calcResult = operand_A;
            default: calcResult = '0;
        endcase
        if (calcBranch) begin
            calcResult = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an accept in RESP is handled exactly like an accept in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef ALU_RESPONDER_ITER_SHIFT_EN
                    state_d = iterStart ? SHIFT : RESP;
`else
                    state_d = RESP;
`endif
                end
            end
`ifdef ALU_RESPONDER_ITER_SHIFT_EN
            SHIFT: begin
                if (count_q == 5'd0) begin
                    state_d = RESP;
                end
            end
`endif
            RESP: begin
                if (accept) begin
`ifdef ALU_RESPONDER_ITER_SHIFT_EN
                    state_d = iterStart ? SHIFT : RESP;
`else
                    state_d = RESP;
`endif
                end else if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the current state.
    always_comb begin
        req_ready  = !reset && ((state_q == IDLE) || ((state_q == RESP) && resp_ready));
        resp_valid = (state_q == RESP);
        busy       = (state_q != IDLE);
    end

    // Result datapath: capture on accept, step the iterative shift, otherwise hold.
    always_ff @(posedge clock) begin
        if (reset) begin
            result_q <= '0;
            zero_q   <= 1'b1;
            branch_q <= 1'b0;
`ifdef ALU_RESPONDER_ITER_SHIFT_EN
            count_q  <= 5'd0;
            ctrl_q   <= 6'd0;
`endif
        end else if (accept) begin
`ifdef ALU_RESPONDER_ITER_SHIFT_EN
            if (iterStart) begin
                result_q <= operand_A;
                count_q  <= shamt;
                ctrl_q   <= ALU_Control;
                branch_q <= 1'b0;
            end else begin
                result_q <= calcResult;
                zero_q   <= (calcResult == '0);
                branch_q <= calcBranch;
            end
`else
            result_q <= calcResult;
            zero_q   <= (calcResult == '0);
            branch_q <= calcBranch;
`endif
        end
`ifdef ALU_RESPONDER_ITER_SHIFT_EN
        else if (state_q == SHIFT) begin
            if (count_q != 5'd0) begin
                count_q <= count_q - 5'd1;
                case (ctrl_q)
                    OP_SLL:  result_q <= result_q << 1;
                    OP_SRL:  result_q <= result_q >> 1;
                    default: result_q <= {result_q[DATA_WIDTH-1], result_q[DATA_WIDTH-1:1]};
                endcase
            end else begin
                zero_q <= (result_q == '0);
            end
        end
`endif
    end

    assign ALU_result = result_q;
    assign zero       = zero_q;
    assign branch     = branch_q;

endmodule

// File: tb/tb_alu_responder.sv
// tb_alu_responder: scoreboard bench for alu_responder (DATA_WIDTH = 32).
// The driver pushes the reference response when a request is accepted; a monitor
// compares every presented response against the queue head and pops on handoff.
// Honours ALU_RESPONDER_ITER_SHIFT_EN for the expected shift latency.
module tb_alu_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  ALU_Control = 6'd0;
    logic [31:0] operand_A = 32'd0;
    logic [31:0] operand_B = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] ALU_result;
    logic        zero;
    logic        branch;
    logic        busy;

    typedef struct {
        logic [31:0] result;
        logic        zero;
        logic        branch;
        int          acceptCycle;
        int          latency;
    } exp_t;

    exp_t expQ[$];
    int   errors = 0;
    int   checks = 0;
    int   cycle = 0;
    int   respMode = 1;
    bit   frontSeen = 1'b0;
    int   idleWait = 0;

    logic [5:0] opList [0:19] = '{6'b000000, 6'b001000, 6'b000001, 6'b000101, 6'b001101,
                                  6'b000010, 6'b000011, 6'b000100, 6'b000110, 6'b000111,
                                  6'b010000, 6'b010001, 6'b010100, 6'b010101, 6'b010110,
                                  6'b010111, 6'b011111, 6'b111111, 6'b001001, 6'b100000};

    alu_responder #(.DATA_WIDTH(32)) dut (
        .clock(clock),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .ALU_Control(ALU_Control),
        .operand_A(operand_A),
        .operand_B(operand_B),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .ALU_result(ALU_result),
        .zero(zero),
        .branch(branch),
        .busy(busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle++;

    // Consumer: resp_ready forced low, forced high, or random, updated just after each edge.
    always @(posedge clock) begin
        #2;
        case (respMode)
            0:       resp_ready = 1'b0;
            1:       resp_ready = 1'b1;
            default: resp_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Reference behaviour from the operation table, using plain arithmetic.
    function automatic exp_t refAlu(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        int unsigned sh;
        logic [31:0] pow;
        logic        cond;
        logic        isBranch;
        sh = b[4:0];
        pow = 32'd1 << sh;
        cond = 1'b0;
        isBranch = 1'b0;
        e.result = 32'd0;
        case (op)
            6'b000000: e.result = a + b;
            6'b001000: e.result = a - b;
            6'b000001: e.result = a * pow;
            6'b000101: e.result = a / pow;
            6'b001101: e.result = a[31] ? ~((~a) / pow) : a / pow;
            6'b000010: e.result = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            6'b000011: e.result = (a < b) ? 32'd1 : 32'd0;
            6'b000100: e.result = a ^ b;
            6'b000110: e.result = a | b;
            6'b000111: e.result = a & b;
            6'b010000: begin isBranch = 1'b1; cond = (a == b); end
            6'b010001: begin isBranch = 1'b1; cond = (a != b); end
            6'b010100: begin isBranch = 1'b1; cond = (int'(a) < int'(b)); end
            6'b010101: begin isBranch = 1'b1; cond = (int'(a) >= int'(b)); end
            6'b010110: begin isBranch = 1'b1; cond = (a < b); end
            6'b010111: begin isBranch = 1'b1; cond = (a >= b); end
            6'b011111: e.result = a;
            default:   e.result = 32'd0;
        endcase
        if (isBranch) e.result = cond ? 32'd1 : 32'd0;
        e.branch = isBranch && cond;
        e.zero = (e.result == 32'd0);
        e.latency = 1;
`ifdef ALU_RESPONDER_ITER_SHIFT_EN
        if ((op == 6'b000001 || op == 6'b000101 || op == 6'b001101) && sh != 0)
            e.latency = 1 + sh;
`endif
        e.acceptCycle = 0;
        return e;
    endfunction

    // Issue one request, hold it until accepted, and record the expected response.
    task automatic applyStimulus(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        bit   accepted;
        int   waited;
        accepted = 1'b0;
        waited = 0;
        ALU_Control = op;
        operand_A = a;
        operand_B = b;
        req_valid = 1'b1;
        while (!accepted && waited < 200) begin
            @(negedge clock);
            if (req_ready) begin
                e = refAlu(op, a, b);
                e.acceptCycle = cycle;
                expQ.push_back(e);
                accepted = 1'b1;
            end
            @(posedge clock);
            #1;
            waited++;
        end
        req_valid = 1'b0;
        if (!accepted) begin
            errors++;
            checks++;
            $display("[TB] FAIL accept_timeout: got no accept, required accept within 200 cycles (op %b)", op);
        end
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (expQ.size() > 0 && n < 500) begin
            @(posedge clock);
            #1;
            n++;
        end
        checkOutput("drain_pending", expQ.size(), 0);
    endtask

    // Monitor: compare each presented response with the queue head, pop on handoff.
    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            if (resp_valid) begin
                idleWait = 0;
                if (expQ.size() == 0) begin
                    errors++;
                    checks++;
                    $display("[TB] FAIL unexpected_resp: got resp_valid=1 result=%h, required no response", ALU_result);
                end else begin
                    e = expQ[0];
                    if (!frontSeen) begin
                        checkOutput("latency", cycle - e.acceptCycle, e.latency);
                        frontSeen = 1'b1;
                    end
                    checkOutput("ALU_result", ALU_result, e.result);
                    checkOutput("zero", zero, e.zero);
                    checkOutput("branch", branch, e.branch);
                    checkOutput("busy_in_resp", busy, 1);
                    if (!resp_ready) checkOutput("req_ready_stalled", req_ready, 0);
                    if (resp_ready) begin
                        void'(expQ.pop_front());
                        frontSeen = 1'b0;
                    end
                end
            end else if (expQ.size() > 0) begin
                idleWait++;
                if (idleWait > 200) begin
                    errors++;
                    checks++;
                    $display("[TB] FAIL resp_timeout: got no response, required one within 200 cycles");
                    expQ.delete();
                    frontSeen = 1'b0;
                    idleWait = 0;
                end
            end
        end
    end

    initial begin
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        // Reset state, and req_ready low during reset.
        @(negedge clock);
        checkOutput("rst_req_ready", req_ready, 0);
        checkOutput("rst_resp_valid", resp_valid, 0);
        checkOutput("rst_result", ALU_result, 0);
        checkOutput("rst_zero", zero, 1);
        checkOutput("rst_branch", branch, 0);
        checkOutput("rst_busy", busy, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        checkOutput("post_rst_req_ready", req_ready, 1);
        @(posedge clock);
        #1;

        // Directed cases from the operation table and boundaries.
        applyStimulus(6'b000000, 32'd2, 32'd4);
        applyStimulus(6'b001000, 32'd2, 32'd4);
        applyStimulus(6'b000010, 32'd2, 32'd4);
        applyStimulus(6'b001101, 32'h8000_0000, 32'd4);
        applyStimulus(6'b001101, 32'h0000_000A, 32'd4);
        applyStimulus(6'b010111, 32'd2, 32'd4);
        applyStimulus(6'b010110, 32'd2, 32'd4);
        applyStimulus(6'b111111, 32'h1234_5678, 32'd9);
        applyStimulus(6'b011111, 32'hDEAD_BEEF, 32'd0);
        applyStimulus(6'b000001, 32'h0000_0003, 32'd0);
        applyStimulus(6'b000001, 32'h0000_0003, 32'd31);
        applyStimulus(6'b010100, 32'hFFFF_FFFF, 32'd1);
        applyStimulus(6'b000011, 32'hFFFF_FFFF, 32'd1);
        waitDrain();

        // Stall for three cycles, then release together with a new ADD.
        respMode = 0;
        @(posedge clock);
        #1;
        applyStimulus(6'b000000, 32'd7, 32'd8);
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        respMode = 1;
        applyStimulus(6'b000000, 32'd2, 32'd4);
        waitDrain();

        // Randomised traffic with a random consumer.
        respMode = 2;
        for (int i = 0; i < 300; i++) begin
            op = opList[$urandom_range(0, 19)];
            a = $urandom();
            b = ($urandom_range(0, 3) == 0) ? a : $urandom();
            applyStimulus(op, a, b);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clock);
                #1;
            end
        end
        respMode = 1;
        waitDrain();

        // Reset during the second SHIFT cycle (or on a stalled response without iteration).
        respMode = 0;
        @(posedge clock);
        #1;
        applyStimulus(6'b001101, 32'h8000_0000, 32'd4);
        @(posedge clock);
        #1;
        reset = 1'b1;
        expQ.delete();
        frontSeen = 1'b0;
        @(negedge clock);
        checkOutput("mid_rst_req_ready", req_ready, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        respMode = 1;
        @(negedge clock);
        checkOutput("after_rst_resp_valid", resp_valid, 0);
        checkOutput("after_rst_zero", zero, 1);
        checkOutput("after_rst_busy", busy, 0);
        checkOutput("after_rst_result", ALU_result, 0);
        checkOutput("after_rst_req_ready", req_ready, 1);
        repeat (40) @(posedge clock);
        #1;
        applyStimulus(6'b000000, 32'd2, 32'd4);
        waitDrain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
